// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud divisor
// (50 MHz / 9600 baud), also used by the transmitter.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level input. Both flops reset to 1,
// so an idle-high line does not look active while coming out of reset.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ble.sv
// 8N1 UART receiver for the BLE command stream. Define UART_RX_FRAME_ERR_EN to
// add the frame_err output and the BREAK state for bad stop bits.
module uart_rx_ble
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output rx_state_t  state_dbg
);

  localparam int CW = $clog2(BAUD_DIV);
  // The counter is examined in the cycle it reads 0, so an N-cycle interval loads N-1.
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

  rx_state_t     state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          rx_s;
  logic          baud_done;
  logic          start_seen;
  logic          frame_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic          err_set;
`endif

  rx_sync u_rx_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (RX),
    .sync_out (rx_s)
  );

  assign baud_done = (baud_cnt == '0);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_done ? baud_cnt : baud_cnt - CW'(1);
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    start_seen   = 1'b0;
    frame_done   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_set      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start_seen   = 1'b1;
          baud_cnt_nxt = HALF_LOAD;
          state_nxt    = START;
        end
      end
      START: begin
        if (baud_done) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            baud_cnt_nxt = FULL_LOAD;
            bit_cnt_nxt  = '0;
            state_nxt    = DATA;
          end
        end
      end
      DATA: begin
        if (baud_done) begin
          // LSB arrives first, so shifting right leaves bit 0 at the bottom after 8 samples.
          shift_nxt    = {rx_s, shift_reg[7:1]};
          bit_cnt_nxt  = bit_cnt + 4'd1;
          baud_cnt_nxt = FULL_LOAD;
          if (bit_cnt == 4'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end else begin
            err_set   = 1'b1;
            state_nxt = BREAK;
          end
`else
          frame_done = 1'b1;
          state_nxt  = IDLE;
`endif
        end
      end
`ifdef UART_RX_FRAME_ERR_EN
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // rdy/clr_rdy: rdy rises the edge after a good stop sample and holds until the
  // consumer pulses clr_rdy or the next start bit is detected; a set always beats
  // a clear in the same cycle, and clr_rdy while rdy is low does nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
    end else begin
      if (frame_done) rx_data <= shift_reg;
      if (frame_done)                  rdy <= 1'b1;
      else if (clr_rdy || start_seen)  rdy <= 1'b0;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_err <= 1'b0;
    else if (err_set)  frame_err <= 1'b1;
    else if (clr_rdy)  frame_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx_ble.sv
// Bench for uart_rx_ble at BAUD_DIV = 16: vector table, directed corner cases,
// then random frames scored against pin-level timing arithmetic.
`timescale 1ns/1ps
module tb_uart_rx_ble;
  import uart_pkg::*;

  localparam int BD = 16;
  // Pin start edge to first cycle rdy is visible: 2 sync flops, half-bit start
  // sample, nine more bit times to the stop sample, then one edge to register.
  localparam int RISE_LAT = 2 + BD / 2 + 9 * BD + 1;

  // clock/reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif
  rx_state_t  state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ble #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (rx),
    .clr_rdy   (clr_rdy),
    .rx_data   (rx_data),
    .rdy       (rdy),
`ifdef UART_RX_FRAME_ERR_EN
    .frame_err (frame_err),
`endif
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_bits);
    rx = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BD);
    end
    rx = stop_lvl;
    tick(BD * stop_bits);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  // scoreboard: every rdy rising edge is matched against the expected queue
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       sb_en     = 1'b0;
  logic       prev_rdy  = 1'b0;
  int         rise_cnt  = 0;
  int         rise_cyc  = -1;
  logic [7:0] rise_data = 8'h00;

  always @(negedge clk) begin
    if (rdy === 1'b1 && prev_rdy !== 1'b1) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_rise: got byte %0h with nothing expected at cycle %0d", rx_data, cyc);
        end else begin
          check("sb_data", rx_data, exp_q.pop_front());
          check("sb_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
    end
    prev_rdy = rdy;
  end

  typedef struct {
    logic [7:0] data;
    logic       clr_in_set_cycle;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t       vecs[5];
  int         e;
  int         r0;
  int         bad;
  logic [7:0] rd;
  int         gap;

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    clr_rdy = 1'b0;

    // reset behaviour
    tick(3);
    check("rst_rdy", rdy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (rdy !== 1'b0 || rx_data !== 8'h00 || state_dbg !== IDLE) bad++;
    end
    check("idle_1000_cycles", bad, 0);
`ifdef UART_RX_FRAME_ERR_EN
    check("rst_frame_err", frame_err, 1'b0);
`endif

    // table-driven single frames; some vectors clear in the set cycle (set wins)
    vecs[0] = '{8'h47, 1'b0, 8'h47, RISE_LAT};
    vecs[1] = '{8'h53, 1'b1, 8'h53, RISE_LAT};
    vecs[2] = '{8'h00, 1'b0, 8'h00, RISE_LAT};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, RISE_LAT};
    vecs[4] = '{8'hA5, 1'b0, 8'hA5, RISE_LAT};
    for (int k = 0; k < 5; k++) begin
      e = cyc;
      fork
        send_frame(vecs[k].data, 1'b1, 1);
        begin
          wait_until(e + vecs[k].exp_lat - 1);
          check("vec_rdy_before", rdy, 1'b0);
          clr_rdy = vecs[k].clr_in_set_cycle;
          tick(1);
          clr_rdy = 1'b0;
          check("vec_rdy_rise", rdy, 1'b1);
          check("vec_rx_data", rx_data, vecs[k].exp_data);
          pulse_clr();
          check("vec_rdy_cleared", rdy, 1'b0);
          check("vec_data_held", rx_data, vecs[k].exp_data);
        end
      join
      tick(5);
    end

    // back-to-back frames with no idle gap and no clr_rdy
    e = cyc;
    fork
      begin
        send_frame(8'h47, 1'b1, 1);
        send_frame(8'h53, 1'b1, 1);
      end
      begin
        wait_until(e + RISE_LAT);
        check("b2b_rdy_first", rdy, 1'b1);
        check("b2b_data_first", rx_data, 8'h47);
        wait_until(e + 10 * BD + 2);
        check("b2b_rdy_before_start", rdy, 1'b1);
        wait_until(e + 10 * BD + 3);
        check("b2b_rdy_drop_at_start", rdy, 1'b0);
        check("b2b_data_stable", rx_data, 8'h47);
        wait_until(e + 10 * BD + RISE_LAT);
        check("b2b_rdy_second", rdy, 1'b1);
        check("b2b_data_second", rx_data, 8'h53);
      end
    join
    tick(5);
    pulse_clr();

    // glitch rejection: 5-cycle low pulse
    r0 = rise_cnt;
    e  = cyc;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    check("glitch_in_start", state_dbg, START);
    wait_until(e + 12);
    check("glitch_back_idle", state_dbg, IDLE);
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_data", rx_data, 8'h53);
    tick(200);
    check("glitch_no_frame", rise_cnt - r0, 0);

    // reset during data bit 3 of 8'hA5, then 8'h3C
    r0 = rise_cnt;
    rd = 8'hA5;
    rx = 1'b0;
    tick(BD);
    for (int i = 0; i < 3; i++) begin
      rx = rd[i];
      tick(BD);
    end
    rx = rd[3];
    tick(6);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_state", state_dbg, IDLE);
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    e = cyc;
    send_frame(8'h3C, 1'b1, 1);
    tick(40);
    check("midrst_one_byte", rise_cnt - r0, 1);
    check("midrst_byte", rise_data, 8'h3C);
    check("midrst_cycle", rise_cyc, e + RISE_LAT);
    pulse_clr();

    // bad stop bit
    r0 = rise_cnt;
    e  = cyc;
`ifdef UART_RX_FRAME_ERR_EN
    send_frame(8'h55, 1'b0, 2);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_rdy", rdy, 1'b0);
    check("ferr_no_frame", rise_cnt - r0, 0);
    check("ferr_data_kept", rx_data, 8'h3C);
    tick(20);
    check("ferr_idle", state_dbg, IDLE);
    e = cyc;
    send_frame(8'h47, 1'b1, 1);
    tick(20);
    check("ferr_next_cycle", rise_cyc, e + RISE_LAT);
    check("ferr_next_data", rx_data, 8'h47);
    check("ferr_next_rdy", rdy, 1'b1);
    check("ferr_sticky", frame_err, 1'b1);
    pulse_clr();
    check("ferr_clr_rdy", rdy, 1'b0);
    check("ferr_clr_err", frame_err, 1'b0);
`else
    send_frame(8'h55, 1'b0, 1);
    tick(40);
    check("badstop_rdy_rise", rise_cnt - r0, 1);
    check("badstop_cycle", rise_cyc, e + RISE_LAT);
    check("badstop_data", rise_data, 8'h55);
    check("badstop_idle", state_dbg, IDLE);
    pulse_clr();
`endif

    // random frames and random clr_rdy pulses against the scoreboard
    tick(10);
    sb_en = 1'b1;
    fork
      for (int n = 0; n < 16; n++) begin
        rd  = 8'($urandom_range(0, 255));
        gap = $urandom_range(0, 30);
        tick(gap);
        exp_q.push_back(rd);
        exp_cyc_q.push_back(cyc + RISE_LAT);
        send_frame(rd, 1'b1, 1);
      end
      repeat (40) begin
        tick($urandom_range(5, 60));
        pulse_clr();
      end
    join
    tick(200);
    sb_en = 1'b0;
    check("sb_drained", exp_q.size(), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
